// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: PRGA state encoding, S memory depth, byte type.
package arc4_pkg;

    localparam int unsigned S_DEPTH = 256;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        StIdle,
        StRdLen,
        StWrLen,
        StFetchSi,
        StLatchSi,
        StFetchSj,
        StLatchSj,
        StWrSi,
        StWrSj,
        StFetchPad,
        StLatchPad,
        StWrPt
    } prga_state_e;

endpackage

// File: rtl/prga_drop.sv
// ARC4 PRGA with RC4-drop[N]: discards DROP_N keystream bytes, then XORs the
// keystream with a length-prefixed ciphertext into a length-prefixed plaintext.
module prga_drop
    import arc4_pkg::*;
#(
    parameter int unsigned DROP_N = 0,
    parameter int unsigned MSG_AW = 8,
    parameter int unsigned CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [7:0]        s_addr,
    input  logic [7:0]        s_rddata,
    output logic [7:0]        s_wrdata,
    output logic              s_wren,
    output logic [MSG_AW-1:0] ct_addr,
    input  logic [7:0]        ct_rddata,
    output logic [MSG_AW-1:0] pt_addr,
    output logic [7:0]        pt_wrdata,
    output logic              pt_wren
);

    // Longest message the pt/ct memories can hold (lengths never exceed a byte).
    localparam int unsigned LenMax = (MSG_AW >= 8) ? 255 : ((1 << MSG_AW) - 1);

    prga_state_e       state_q, state_d;
    logic              rdy_q, rdy_d;
    byte_t             s_addr_q, s_addr_d;
    byte_t             s_wrdata_q, s_wrdata_d;
    logic              s_wren_q, s_wren_d;
    logic [MSG_AW-1:0] ct_addr_q, ct_addr_d;
    logic [MSG_AW-1:0] pt_addr_q, pt_addr_d;
    byte_t             pt_wrdata_q, pt_wrdata_d;
    logic              pt_wren_q, pt_wren_d;
    byte_t             i_q, i_d;
    byte_t             j_q, j_d;
    byte_t             si_q, si_d;
    byte_t             sj_q, sj_d;
    byte_t             len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    byte_t             len_sat;

    // Oversized length prefixes clamp to the largest storable message.
    assign len_sat = (32'(ct_rddata) > LenMax) ? byte_t'(LenMax) : ct_rddata;

    // Next-state logic for the FSM and its registered memory-interface outputs.
    always_comb begin
        state_d     = state_q;
        rdy_d       = rdy_q;
        s_addr_d    = s_addr_q;
        s_wrdata_d  = s_wrdata_q;
        s_wren_d    = 1'b0;
        ct_addr_d   = ct_addr_q;
        pt_addr_d   = pt_addr_q;
        pt_wrdata_d = pt_wrdata_q;
        pt_wren_d   = 1'b0;
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        len_d       = len_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d   = StRdLen;
                    rdy_d     = 1'b0;
                    ct_addr_d = '0;
                    i_d       = '0;
                    j_d       = '0;
                    cnt_d     = '0;
                end
            end
            StRdLen: begin
                state_d   = StWrLen;
                pt_addr_d = '0;
                pt_wren_d = 1'b1;
            end
            StWrLen: begin
                len_d = len_sat;
                cnt_d = CNT_W'(1);
                if (len_sat == 8'd0) begin
                    state_d = StIdle;
                    rdy_d   = 1'b1;
                end else begin
                    state_d  = StFetchSi;
                    i_d      = i_q + 8'd1;
                    s_addr_d = i_q + 8'd1;
                end
            end
            StFetchSi: state_d = StLatchSi;
            StLatchSi: begin
                state_d  = StFetchSj;
                si_d     = s_rddata;
                j_d      = j_q + s_rddata;
                s_addr_d = j_q + s_rddata;
            end
            StFetchSj: state_d = StLatchSj;
            StLatchSj: begin
                state_d    = StWrSi;
                sj_d       = s_rddata;
                s_addr_d   = i_q;
                s_wrdata_d = s_rddata;
                s_wren_d   = 1'b1;
            end
            StWrSi: begin
                state_d    = StWrSj;
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
                s_wren_d   = 1'b1;
            end
            StWrSj: begin
                if (cnt_q > CNT_W'(DROP_N)) begin
                    state_d   = StFetchPad;
                    s_addr_d  = si_q + sj_q;
                    ct_addr_d = MSG_AW'(cnt_q - CNT_W'(DROP_N));
                end else begin
                    // Discarded keystream byte: straight on to the next one.
                    state_d  = StFetchSi;
                    cnt_d    = cnt_q + CNT_W'(1);
                    i_d      = i_q + 8'd1;
                    s_addr_d = i_q + 8'd1;
                end
            end
            StFetchPad: state_d = StLatchPad;
            StLatchPad: begin
                state_d     = StWrPt;
                pt_addr_d   = ct_addr_q;
                pt_wrdata_d = s_rddata ^ ct_rddata;
                pt_wren_d   = 1'b1;
            end
            StWrPt: begin
                if (cnt_q == CNT_W'(DROP_N) + CNT_W'(len_q)) begin
                    state_d = StIdle;
                    rdy_d   = 1'b1;
                end else begin
                    state_d  = StFetchSi;
                    cnt_d    = cnt_q + CNT_W'(1);
                    i_d      = i_q + 8'd1;
                    s_addr_d = i_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rdy_q       <= 1'b1;
            s_addr_q    <= '0;
            s_wrdata_q  <= '0;
            s_wren_q    <= 1'b0;
            ct_addr_q   <= '0;
            pt_addr_q   <= '0;
            pt_wrdata_q <= '0;
            pt_wren_q   <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            s_addr_q    <= s_addr_d;
            s_wrdata_q  <= s_wrdata_d;
            s_wren_q    <= s_wren_d;
            ct_addr_q   <= ct_addr_d;
            pt_addr_q   <= pt_addr_d;
            pt_wrdata_q <= pt_wrdata_d;
            pt_wren_q   <= pt_wren_d;
            i_q         <= i_d;
            j_q         <= j_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rdy      = rdy_q;
    assign s_addr   = s_addr_q;
    assign s_wrdata = s_wrdata_q;
    assign s_wren   = s_wren_q;
    assign ct_addr  = ct_addr_q;
    assign pt_addr  = pt_addr_q;
    assign pt_wren  = pt_wren_q;
    // The length byte only arrives from ct memory during StWrLen, so pt[0] data is
    // taken straight from the (registered) memory output in that one state.
    assign pt_wrdata = (state_q == StWrLen) ? len_sat : pt_wrdata_q;

endmodule

// File: tb/tb_prga_drop.sv
// Bench for prga_drop: three builds (drop 0, drop 3, 4-bit message address)
// share one set of memories; only the selected build is ever started.
module tb_prga_drop;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] en_v;
    int sel;
    logic load;

    logic [7:0] s_rddata, ct_rddata;

    logic       rdy0, rdy1, rdy2;
    logic [7:0] s_addr0, s_addr1, s_addr2;
    logic [7:0] s_wrdata0, s_wrdata1, s_wrdata2;
    logic       s_wren0, s_wren1, s_wren2;
    logic [7:0] ct_addr0, ct_addr1;
    logic [3:0] ct_addr2;
    logic [7:0] pt_addr0, pt_addr1;
    logic [3:0] pt_addr2;
    logic [7:0] pt_wrdata0, pt_wrdata1, pt_wrdata2;
    logic       pt_wren0, pt_wren1, pt_wren2;

    logic       m_rdy, m_s_wren, m_pt_wren;
    logic [7:0] m_s_addr, m_s_wrdata, m_ct_addr, m_pt_addr, m_pt_wrdata;

    logic [7:0] smem [256];
    logic [7:0] ctmem [256];
    logic [7:0] ptmem [256];
    logic [7:0] s_init [256];
    logic [7:0] ct_init [256];

    // Model results
    int         exp_addr [256];
    logic [7:0] exp_data [256];
    int         exp_n;
    int         exp_len;
    logic [7:0] pt_img [256];
    logic [7:0] s_exp [256];

    int n_tests = 0;
    int n_fail  = 0;
    int mon_ptr = 0;

    always #5 clk = ~clk;

    prga_drop #(.DROP_N(0), .MSG_AW(8), .CNT_W(11)) u_d0 (
        .clk(clk), .rst(rst), .en(en_v[0]), .rdy(rdy0),
        .s_addr(s_addr0), .s_rddata(s_rddata), .s_wrdata(s_wrdata0), .s_wren(s_wren0),
        .ct_addr(ct_addr0), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr0), .pt_wrdata(pt_wrdata0), .pt_wren(pt_wren0)
    );

    prga_drop #(.DROP_N(3), .MSG_AW(8), .CNT_W(11)) u_d3 (
        .clk(clk), .rst(rst), .en(en_v[1]), .rdy(rdy1),
        .s_addr(s_addr1), .s_rddata(s_rddata), .s_wrdata(s_wrdata1), .s_wren(s_wren1),
        .ct_addr(ct_addr1), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr1), .pt_wrdata(pt_wrdata1), .pt_wren(pt_wren1)
    );

    prga_drop #(.DROP_N(0), .MSG_AW(4), .CNT_W(11)) u_aw4 (
        .clk(clk), .rst(rst), .en(en_v[2]), .rdy(rdy2),
        .s_addr(s_addr2), .s_rddata(s_rddata), .s_wrdata(s_wrdata2), .s_wren(s_wren2),
        .ct_addr(ct_addr2), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr2), .pt_wrdata(pt_wrdata2), .pt_wren(pt_wren2)
    );

    always_comb begin
        case (sel)
            1: begin
                m_rdy = rdy1; m_s_addr = s_addr1; m_s_wrdata = s_wrdata1; m_s_wren = s_wren1;
                m_ct_addr = ct_addr1; m_pt_addr = pt_addr1; m_pt_wrdata = pt_wrdata1;
                m_pt_wren = pt_wren1;
            end
            2: begin
                m_rdy = rdy2; m_s_addr = s_addr2; m_s_wrdata = s_wrdata2; m_s_wren = s_wren2;
                m_ct_addr = {4'b0, ct_addr2}; m_pt_addr = {4'b0, pt_addr2};
                m_pt_wrdata = pt_wrdata2; m_pt_wren = pt_wren2;
            end
            default: begin
                m_rdy = rdy0; m_s_addr = s_addr0; m_s_wrdata = s_wrdata0; m_s_wren = s_wren0;
                m_ct_addr = ct_addr0; m_pt_addr = pt_addr0; m_pt_wrdata = pt_wrdata0;
                m_pt_wren = pt_wren0;
            end
        endcase
    end

    // Synchronous memories, one-cycle read latency
    always @(posedge clk) begin
        s_rddata  <= smem[m_s_addr];
        ct_rddata <= ctmem[m_ct_addr];
        if (load) begin
            smem  <= s_init;
            ctmem <= ct_init;
            for (int n = 0; n < 256; n++) ptmem[n] <= 8'hEE;
        end else begin
            if (m_s_wren) smem[m_s_addr] <= m_s_wrdata;
            if (m_pt_wren) ptmem[m_pt_addr] <= m_pt_wrdata;
        end
    end

    // Compare process: every write cycle is checked against the model sequence
    always @(negedge clk) begin
        if (m_s_wren || m_pt_wren) begin
            n_tests++;
            if (m_s_wren && m_pt_wren) begin
                n_fail++;
                $display("FAIL wren_excl: s_wren=%0b pt_wren=%0b, required not both", m_s_wren,
                         m_pt_wren);
            end
        end
        if (m_pt_wren) begin
            if (m_pt_addr == 8'd0) mon_ptr = 0;
            n_tests++;
            if (mon_ptr >= exp_n) begin
                n_fail++;
                $display("FAIL pt_extra: write pt[%0d]=%02h, required no write", m_pt_addr,
                         m_pt_wrdata);
            end else if (int'(m_pt_addr) != exp_addr[mon_ptr] ||
                         m_pt_wrdata != exp_data[mon_ptr]) begin
                n_fail++;
                $display("FAIL pt_write#%0d: got pt[%0d]=%02h, required pt[%0d]=%02h", mon_ptr,
                         m_pt_addr, m_pt_wrdata, exp_addr[mon_ptr], exp_data[mon_ptr]);
            end
            mon_ptr++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // S after key scheduling with key "Key"
    task automatic ksa_key();
        logic [7:0] key [3];
        int s [256];
        int j, t;
        key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + int'(key[n % 3])) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        for (int n = 0; n < 256; n++) s_init[n] = 8'(s[n]);
    endtask

    // Plain RC4-drop[N] over a copy of S: expected pt writes, pt image and final S
    task automatic build_expect(input int drop, input int lenmax);
        int s [256];
        int i, j, t, ks, len;
        for (int n = 0; n < 256; n++) begin
            s[n] = int'(s_init[n]);
            pt_img[n] = 8'hEE;
        end
        len = int'(ct_init[0]);
        if (len > lenmax) len = lenmax;
        exp_len = len;
        exp_addr[0] = 0; exp_data[0] = 8'(len); pt_img[0] = 8'(len);
        exp_n = 1;
        i = 0; j = 0;
        for (int k = 1; k <= drop + len; k++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks = s[(s[i] + s[j]) % 256];
            if (k > drop) begin
                exp_addr[exp_n] = k - drop;
                exp_data[exp_n] = 8'(ks) ^ ct_init[k - drop];
                pt_img[k - drop] = exp_data[exp_n];
                exp_n++;
            end
        end
        for (int n = 0; n < 256; n++) s_exp[n] = 8'(s[n]);
    endtask

    task automatic load_mem();
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
    endtask

    // mode 0: single en pulse; 1: also toggle en while busy; 2: reset after pt[3] write
    task automatic run(input int mode, output int cyc, output int s_wr, output int pt_wr,
                       output int first_wr);
        bit done;
        done = 0; cyc = 0; s_wr = 0; pt_wr = 0; first_wr = -1;
        en_v = '0;
        en_v[sel] = 1'b1;
        while (!done && cyc < 3000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            en_v = '0;
            if (m_s_wren) s_wr++;
            if (m_pt_wren) begin
                pt_wr++;
                if (m_pt_addr != 8'd0 && first_wr < 0) first_wr = cyc;
            end
            if (mode == 2 && m_pt_wren && m_pt_addr == 8'd3) begin
                rst = 1'b1;
                @(posedge clk);
                cyc++;
                @(negedge clk);
                rst = 1'b0;
                done = 1;
            end else if (m_rdy) begin
                done = 1;
            end else if (mode == 1) begin
                en_v[sel] = cyc[0];
            end
        end
        if (!done) chk("run_timeout", cyc, -1);
    endtask

    task automatic idle_writes(input int n, output int wr);
        wr = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (m_s_wren || m_pt_wren) wr++;
        end
    endtask

    task automatic check_done(input string tag, input int drop, input int lat_exp,
                              input int cyc, input int s_wr, input int pt_wr);
        int bad_pt, bad_s;
        bad_pt = 0; bad_s = 0;
        chk({tag, "_latency"}, cyc, lat_exp);
        chk({tag, "_s_wren_pulses"}, s_wr, 2 * (drop + exp_len));
        chk({tag, "_pt_writes"}, pt_wr, exp_n);
        chk({tag, "_monitor_count"}, mon_ptr, exp_n);
        for (int n = 0; n < 256; n++) begin
            if (ptmem[n] !== pt_img[n]) bad_pt++;
            if (smem[n] !== s_exp[n]) bad_s++;
        end
        chk({tag, "_pt_mem_mismatches"}, bad_pt, 0);
        chk({tag, "_s_mem_mismatches"}, bad_s, 0);
    endtask

    task automatic setup_plaintext_ct();
        logic [7:0] ct_lit [10];
        ct_lit = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        for (int n = 0; n < 256; n++) ct_init[n] = 8'h00;
        for (int n = 0; n < 10; n++) ct_init[n] = ct_lit[n];
    endtask

    initial begin
        logic [7:0] pt_lit [10];
        int cyc, s_wr, pt_wr, first_wr, wr;
        pt_lit = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        rst = 1'b1; en_v = '0; sel = 0; load = 1'b0; exp_n = 0; exp_len = 0;
        for (int n = 0; n < 256; n++) begin
            s_init[n] = 8'(n); ct_init[n] = 8'h00;
        end
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset_rdy_all", int'({rdy2, rdy1, rdy0}), 7);
        chk("reset_wren_all", int'({s_wren0, s_wren1, s_wren2, pt_wren0, pt_wren1, pt_wren2}), 0);
        chk("reset_s_addr", int'(s_addr0), 0);
        chk("reset_s_wrdata", int'(s_wrdata0), 0);
        chk("reset_ct_addr", int'(ct_addr0), 0);
        chk("reset_pt_addr", int'(pt_addr0), 0);
        chk("reset_pt_wrdata", int'(pt_wrdata0), 0);
        rst = 1'b0;
        @(negedge clk);

        // Key "Key", no drop, "Plaintext"
        sel = 0;
        ksa_key();
        setup_plaintext_ct();
        build_expect(0, 255);
        for (int n = 0; n < 10; n++) chk($sformatf("model_plaintext_%0d", n), int'(pt_img[n]),
                                         int'(pt_lit[n]));
        load_mem();
        run(0, cyc, s_wr, pt_wr, first_wr);
        check_done("drop0", 0, 84, cyc, s_wr, pt_wr);
        chk("drop0_first_data_write_cycle", first_wr, 11);

        // Key "Key", drop 3
        sel = 1;
        ksa_key();
        for (int n = 0; n < 256; n++) ct_init[n] = 8'h00;
        ct_init[0] = 8'h03; ct_init[1] = 8'h81; ct_init[2] = 8'hB7; ct_init[3] = 8'h34;
        build_expect(3, 255);
        chk("model_drop3_pt", int'({pt_img[0], pt_img[1], pt_img[2], pt_img[3]}), 32'h03000000);
        load_mem();
        run(0, cyc, s_wr, pt_wr, first_wr);
        check_done("drop3", 3, 48, cyc, s_wr, pt_wr);
        chk("drop3_first_data_write_cycle", first_wr, 29);

        // Zero-length message
        sel = 0;
        ksa_key();
        for (int n = 0; n < 256; n++) ct_init[n] = 8'h5A;
        ct_init[0] = 8'h00;
        build_expect(0, 255);
        load_mem();
        run(0, cyc, s_wr, pt_wr, first_wr);
        check_done("len0", 0, 3, cyc, s_wr, pt_wr);

        // en toggled while busy: exactly one run
        ksa_key();
        setup_plaintext_ct();
        build_expect(0, 255);
        load_mem();
        run(1, cyc, s_wr, pt_wr, first_wr);
        check_done("en_busy", 0, 84, cyc, s_wr, pt_wr);
        idle_writes(12, wr);
        chk("en_busy_idle_writes", wr, 0);
        chk("en_busy_idle_rdy", int'(m_rdy), 1);

        // Reset after pt[3]
        ksa_key();
        setup_plaintext_ct();
        build_expect(0, 255);
        load_mem();
        run(2, cyc, s_wr, pt_wr, first_wr);
        chk("abort_rdy", int'(m_rdy), 1);
        chk("abort_wren", int'({m_s_wren, m_pt_wren}), 0);
        chk("abort_monitor_count", mon_ptr, 4);
        idle_writes(20, wr);
        chk("abort_idle_writes", wr, 0);
        chk("abort_pt3", int'(ptmem[3]), int'(pt_lit[3]));
        chk("abort_pt4_untouched", int'(ptmem[4]), 32'hEE);
        ksa_key();
        load_mem();
        run(0, cyc, s_wr, pt_wr, first_wr);
        check_done("after_abort", 0, 84, cyc, s_wr, pt_wr);

        // 4-bit message address: length prefix 0x20 saturates to 15
        sel = 2;
        ksa_key();
        for (int n = 0; n < 256; n++) ct_init[n] = 8'((n * 37) % 256);
        ct_init[0] = 8'h20;
        build_expect(0, 15);
        chk("model_aw4_len", exp_len, 15);
        load_mem();
        run(0, cyc, s_wr, pt_wr, first_wr);
        check_done("aw4", 0, 138, cyc, s_wr, pt_wr);
        chk("aw4_pt0", int'(ptmem[0]), 15);
        chk("aw4_pt16_untouched", int'(ptmem[16]), 32'hEE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
